// File: rtl/riscv_mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter.
// Optional feature macro used by the top: RISCV_MEM_ARB_TIMEOUT_EN.
package riscv_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } mem_req_t;

  function automatic mem_req_t build_req(input logic [31:0] addr, input logic [31:0] wdata,
                                         input logic [3:0] be, input logic we);
    mem_req_t r;
    r.addr  = addr;
    r.wdata = wdata;
    r.be    = be;
    r.we    = we;
    return r;
  endfunction

endpackage

// File: rtl/riscv_mem_arb_prio.sv
// Winner select for the arbiter: data has priority, fetch is forced
// through after STARVE_LIMIT consecutive data wins over a pending fetch.
module riscv_mem_arb_prio #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic accept,
  input  logic i_req,
  input  logic d_req,
  output logic grant_i,
  output logic grant_d
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt_r;
  logic          starved_s;

  // Combinational winner select, only while the FSM can accept.
  always_comb begin
    starved_s = (starve_cnt_r == LIMIT_C);
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    if (accept) begin
      if (i_req && (!d_req || starved_s)) begin
        grant_i = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end else begin
        grant_d = 1'b0;
      end
    end else begin
      grant_i = 1'b0;
    end
  end

  // Count data wins over a waiting fetch; saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= '0;
    end else if (grant_i) begin
      starve_cnt_r <= '0;
    end else if (grant_d && i_req && !starved_s) begin
      starve_cnt_r <= starve_cnt_r + CW'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Single-outstanding arbiter sharing the cache port between IF and MEM.
// Define RISCV_MEM_ARB_TIMEOUT_EN to abort a response that never arrives.
module riscv_mem_arbiter
  import riscv_mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic        i_err,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        mem_abort
);

  arb_state_e state_r, state_nxt_s;
  arb_owner_e owner_r;
  mem_req_t   payload_r;
  logic       accept_s, grant_i_s, grant_d_s, resp_fire_s, timeout_s;

  assign accept_s    = (state_r == IDLE) && !rst;
  assign resp_fire_s = (state_r == RESP) && mem_rvalid && !rst;

  riscv_mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk     (clk),
    .rst     (rst),
    .accept  (accept_s),
    .i_req   (i_req),
    .d_req   (d_req),
    .grant_i (grant_i_s),
    .grant_d (grant_d_s)
  );

`ifdef RISCV_MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_r;

  // A real mem_rvalid in the expiry cycle takes precedence over the abort.
  assign timeout_s = (state_r == RESP) && !mem_rvalid && !rst &&
                     (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));

  // Counts RESP cycles spent waiting for a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_r <= '0;
    end else if ((state_r == RESP) && !mem_rvalid && !timeout_s) begin
      tmo_cnt_r <= tmo_cnt_r + TW'(1);
    end else begin
      tmo_cnt_r <= '0;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state logic for the request/response sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = (grant_i_s || grant_d_s) ? REQ : IDLE;
      REQ:     state_nxt_s = mem_gnt ? RESP : REQ;
      RESP:    state_nxt_s = (resp_fire_s || timeout_s) ? IDLE : RESP;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State and owner registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      owner_r <= OWNER_I;
    end else begin
      state_r <= state_nxt_s;
      if (grant_d_s || grant_i_s) begin
        owner_r <= grant_d_s ? OWNER_D : OWNER_I;
      end else begin
        owner_r <= owner_r;
      end
    end
  end

  // Payload latch; fetches are full-word reads.
  always_ff @(posedge clk) begin
    if (grant_d_s) begin
      payload_r <= build_req(d_addr, d_wdata, d_be, d_we);
    end else if (grant_i_s) begin
      payload_r <= build_req(i_addr, 32'h0000_0000, 4'hF, 1'b0);
    end else begin
      payload_r <= payload_r;
    end
  end

  // Grant, downstream request and response routing to the owner.
  always_comb begin
    i_gnt     = grant_i_s;
    d_gnt     = grant_d_s;
    mem_req   = (state_r == REQ);
    mem_addr  = payload_r.addr;
    mem_wdata = payload_r.wdata;
    mem_be    = payload_r.be;
    mem_we    = payload_r.we;
    mem_abort = timeout_s;
    i_rvalid  = 1'b0;
    i_err     = 1'b0;
    i_rdata   = 32'h0000_0000;
    d_rvalid  = 1'b0;
    d_err     = 1'b0;
    d_rdata   = 32'h0000_0000;
    if (resp_fire_s || timeout_s) begin
      if (owner_r == OWNER_D) begin
        d_rvalid = 1'b1;
        d_err    = timeout_s;
        d_rdata  = resp_fire_s ? mem_rdata : 32'h0000_0000;
      end else begin
        i_rvalid = 1'b1;
        i_err    = timeout_s;
        i_rdata  = resp_fire_s ? mem_rdata : 32'h0000_0000;
      end
    end else begin
      d_rvalid = 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed self-checking bench for riscv_mem_arbiter.
// The timeout scenario runs when RISCV_MEM_ARB_TIMEOUT_EN is defined.
module tb_riscv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_gnt, i_rvalid, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, mem_abort;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  riscv_mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_abort(mem_abort)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b1; i_addr = 32'h0000_0000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

    // Reset: requests are present but nothing may be granted
    step(); sample();
    chk("rst_gnt", {30'h0, i_gnt, d_gnt}, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_abort_err", {29'h0, mem_abort, i_err, d_err}, 32'h0);
    i_req = 1'b0; d_req = 1'b0;
    step(); rst = 1'b0;

    // Single fetch
    i_req = 1'b1; i_addr = 32'h0000_0100;
    sample();
    chk("f_c0_gnt", {30'h0, i_gnt, d_gnt}, 32'h2);
    chk("f_c0_memreq", {31'h0, mem_req}, 32'h0);
    step(); i_req = 1'b0; mem_gnt = 1'b1;
    sample();
    chk("f_c1_memreq", {31'h0, mem_req}, 32'h1);
    chk("f_c1_addr", mem_addr, 32'h0000_0100);
    chk("f_c1_we", {31'h0, mem_we}, 32'h0);
    step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    sample();
    chk("f_c2_rvalid", {30'h0, i_rvalid, d_rvalid}, 32'h2);
    chk("f_c2_rdata", i_rdata, 32'hDEAD_BEEF);
    chk("f_c2_err", {30'h0, i_err, d_err}, 32'h0);
    step(); mem_rvalid = 1'b0;

    // Contention: data store wins, fetch follows right after d_rvalid
    i_req = 1'b1; i_addr = 32'h0000_0300;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0200; d_be = 4'b0011; d_wdata = 32'hCAFE_0001;
    sample();
    chk("c_gnt", {30'h0, i_gnt, d_gnt}, 32'h1);
    step(); d_req = 1'b0; mem_gnt = 1'b1;
    sample();
    chk("c_memreq", {31'h0, mem_req}, 32'h1);
    chk("c_we", {31'h0, mem_we}, 32'h1);
    chk("c_be", {28'h0, mem_be}, 32'h3);
    chk("c_addr", mem_addr, 32'h0000_0200);
    chk("c_wdata", mem_wdata, 32'hCAFE_0001);
    chk("c_req_nognt", {30'h0, i_gnt, d_gnt}, 32'h0);
    step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    sample();
    chk("c_rvalid", {30'h0, i_rvalid, d_rvalid}, 32'h1);
    chk("c_resp_nognt", {30'h0, i_gnt, d_gnt}, 32'h0);
    step(); mem_rvalid = 1'b0;
    sample();
    chk("c_fetch_gnt", {30'h0, i_gnt, d_gnt}, 32'h2);
    step(); i_req = 1'b0; mem_gnt = 1'b1;
    sample();
    chk("c_fetch_addr", mem_addr, 32'h0000_0300);
    chk("c_fetch_we", {31'h0, mem_we}, 32'h0);
    step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0055;
    sample();
    chk("c_fetch_rdata", i_rdata, 32'h0000_0055);
    step(); mem_rvalid = 1'b0;

    // Starvation: D, D, D, D, I, D with both requests held high
    i_req = 1'b1; i_addr = 32'h0000_1000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000; d_be = 4'hF;
    for (int k = 0; k < 6; k++) begin
      sample();
      chk($sformatf("s_cnt%0d", k), 32'(u_dut.u_prio.starve_cnt_r), (k < 5) ? k : 0);
      chk($sformatf("s_gnt%0d", k), {30'h0, i_gnt, d_gnt}, (k == 4) ? 32'h2 : 32'h1);
      step(); mem_gnt = 1'b1;
      if (k == 5) begin
        i_req = 1'b0; d_req = 1'b0;
      end
      step(); mem_gnt = 1'b0; mem_rvalid = 1'b1;
      step(); mem_rvalid = 1'b0;
    end

    // Stall: mem_gnt low for 5 cycles, payload held, no second grant
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0400;
    sample();
    chk("st_gnt", {30'h0, i_gnt, d_gnt}, 32'h1);
    step(); d_req = 1'b0; i_req = 1'b1; i_addr = 32'h0000_0500;
    d_addr = 32'hFFFF_FFFF;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) mem_gnt = 1'b1;
      sample();
      chk($sformatf("st_req%0d", c), {31'h0, mem_req}, 32'h1);
      chk($sformatf("st_addr%0d", c), mem_addr, 32'h0000_0400);
      chk($sformatf("st_nognt%0d", c), {30'h0, i_gnt, d_gnt}, 32'h0);
      step();
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0444;
    sample();
    chk("st_rdata", d_rdata, 32'h0000_0444);
    step(); mem_rvalid = 1'b0;
    sample();
    chk("st_fetch_gnt", {30'h0, i_gnt, d_gnt}, 32'h2);
    step(); i_req = 1'b0; mem_gnt = 1'b1;
    step(); mem_gnt = 1'b0; mem_rvalid = 1'b1;
    step(); mem_rvalid = 1'b0;

    // Reset during RESP, late response must be dropped
    d_req = 1'b1; d_addr = 32'h0000_0600;
    sample();
    chk("r_gnt", {30'h0, i_gnt, d_gnt}, 32'h1);
    step(); d_req = 1'b0; mem_gnt = 1'b1;
    step(); mem_gnt = 1'b0; rst = 1'b1;
    step(); rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0BAD;
    sample();
    chk("r_no_rvalid", {30'h0, i_rvalid, d_rvalid}, 32'h0);
    chk("r_idle", {31'h0, mem_req}, 32'h0);
    step(); mem_rvalid = 1'b0; d_req = 1'b1; d_addr = 32'h0000_0700;
    sample();
    chk("r_new_gnt", {30'h0, i_gnt, d_gnt}, 32'h1);
    step(); d_req = 1'b0; mem_gnt = 1'b1;
    sample();
    chk("r_new_addr", mem_addr, 32'h0000_0700);
    step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0077;
    sample();
    chk("r_new_rdata", d_rdata, 32'h0000_0077);
    step(); mem_rvalid = 1'b0;

    // Response that does not come back promptly
    d_req = 1'b1; d_addr = 32'h0000_0800; mem_rdata = 32'h5555_AAAA;
    sample();
    chk("t_gnt", {30'h0, i_gnt, d_gnt}, 32'h1);
    step(); d_req = 1'b0; mem_gnt = 1'b1;
    step(); mem_gnt = 1'b0;
`ifdef RISCV_MEM_ARB_TIMEOUT_EN
    for (int c = 1; c < 8; c++) begin
      sample();
      chk($sformatf("t_wait%0d", c), {29'h0, mem_abort, d_rvalid, d_err}, 32'h0);
      step();
    end
    sample();
    chk("t_abort", {29'h0, mem_abort, d_rvalid, d_err}, 32'h7);
    chk("t_rdata", d_rdata, 32'h0000_0000);
    chk("t_i_quiet", {30'h0, i_rvalid, i_err}, 32'h0);
    step(); d_req = 1'b1; d_addr = 32'h0000_0900;
    sample();
    chk("t_after", {29'h0, mem_abort, d_rvalid, mem_req}, 32'h0);
    chk("t_idle_gnt", {30'h0, i_gnt, d_gnt}, 32'h1);
    step(); d_req = 1'b0; mem_gnt = 1'b1;
    step(); mem_gnt = 1'b0; mem_rvalid = 1'b1;
    step(); mem_rvalid = 1'b0;
`else
    for (int c = 1; c < 12; c++) begin
      sample();
      chk($sformatf("t_wait%0d", c), {29'h0, mem_abort, d_rvalid, d_err}, 32'h0);
      step();
    end
    mem_rvalid = 1'b1;
    sample();
    chk("t_late_resp", {29'h0, mem_abort, d_rvalid, d_err}, 32'h2);
    chk("t_late_rdata", d_rdata, 32'h5555_AAAA);
    step(); mem_rvalid = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Shares one unified memory port, toward the L1 cache (16 KB) backed by the L2 cache (64 KB), between the instruction-fetch requester (IF stage) and the data requester (MEM stage). It is a single-outstanding-transaction arbiter. Data requests have priority, and a bounded starvation counter guarantees forward progress for fetch. It sits between the pipeline memory interfaces and the cache port, and owns sequencing of request, acceptance and response.

## Interface
- `STARVE_LIMIT`, default 4: number of consecutive data wins over a pending fetch before fetch is forced to win.
- `TIMEOUT_CYCLES`, default 64: number of RESP cycles before abort. Used only with the timeout feature.
- `clk` in, 1: the single clock.
- `rst` in, 1: reset. Synchronous and active-high.
- `i_req`, `i_addr[31:0]` in: fetch request. Held stable until `i_gnt`.
- `i_gnt`, `i_rvalid`, `i_err` out, 1 each; `i_rdata` out, 32: fetch grant and response.
- `d_req`, `d_we` in, 1 each; `d_addr[31:0]`, `d_wdata[31:0]`, `d_be[3:0]` in: data request. Held stable until `d_gnt`.
- `d_gnt`, `d_rvalid`, `d_err` out, 1 each; `d_rdata` out, 32: data grant and response.
- `mem_req`, `mem_we` out, 1 each; `mem_addr` out, 32; `mem_wdata` out, 32; `mem_be` out, 4: downstream request.
- `mem_gnt`, `mem_rvalid` in, 1 each; `mem_rdata` in, 32: downstream acceptance and response.
- `mem_abort` out, 1: one-cycle cancel of the outstanding transaction.

## Operation
- FSM states:
  - IDLE: accepts a request.
  - REQ: drives `mem_req`.
  - RESP: waits for `mem_rvalid`.
- IDLE:
  - If any `*_req` is high, the winner's `*_gnt` is driven combinationally in the same cycle.
  - The winner's payload and owner ID are latched on that edge, and the FSM moves to REQ.
- Winner selection:
  - `i_req` wins if `d_req` is low, or if `starve_cnt == STARVE_LIMIT`.
  - Otherwise `d_req` wins.
- `starve_cnt`:
  - Increments (saturating) when data wins while `i_req` is high.
  - Clears when fetch is granted.
  - Unchanged otherwise.
- REQ:
  - `mem_req` = 1 with the latched payload. Payload is held constant while in REQ.
  - `mem_gnt` = 1 moves the FSM to RESP.
- RESP:
  - `mem_rvalid` drives the owner's `*_rvalid` and passes `mem_rdata` through to the owner's `*_rdata`, both combinationally.
  - The non-owner's `*_rvalid` stays 0.
  - The FSM moves to IDLE.
  - Writes also complete on `mem_rvalid`; rdata is ignored by the requester.
- `mem_rvalid` in IDLE or REQ is ignored.
- `*_err` is 0 except on timeout (see Configuration).
- Reset values: state IDLE, `starve_cnt` 0, timeout counter 0. All `*_gnt`, `*_rvalid`, `*_err`, `mem_req` and `mem_abort` are 0.
- Latched payload registers (addr, wdata, be, we) have no reset.
- Reset mid-transaction: the outstanding access is abandoned and no response is forwarded.

## Timing
- Cycle 0: request accepted (`*_gnt` = 1).
- Cycle 1: `mem_req` = 1.
- Earliest response: if `mem_gnt` = 1 in cycle 1, the earliest `*_rvalid` is cycle 2.
- Throughput: the next grant is possible in the cycle after `*_rvalid`. Peak rate is one transaction per 3 cycles.
- `mem_req` stays high across `mem_gnt` = 0 stall cycles with an unchanged payload.
- `*_gnt` is a one-cycle pulse. The requester may change `*_req` or payload only after its gnt.
- Simultaneous `i_req` and `d_req` in IDLE: exactly one gnt is asserted.
- `starve_cnt` is `$clog2(STARVE_LIMIT+1)` bits wide.

## Configuration
- Macro: `RISCV_MEM_ARB_TIMEOUT_EN`.
- With the macro:
  - A counter runs in RESP.
  - When it reaches `TIMEOUT_CYCLES` without `mem_rvalid`, the arbiter pulses `mem_abort`, the owner's `*_rvalid`, and the owner's `*_err` for one cycle, with `*_rdata` = 32'h0, and returns to IDLE.
  - `mem_rvalid` arriving in the same cycle as the timeout wins: normal response, no abort.
  - The downstream port drops the aborted transaction.
- Without the macro: no counter; `mem_abort` and `*_err` are tied 0; RESP waits indefinitely.

## Structure
- Package `riscv_mem_arb_pkg`:
  - `arb_state_e` enum: IDLE, REQ, RESP.
  - `arb_owner_e` enum: OWNER_I, OWNER_D.
  - Packed struct `mem_req_t`: addr, wdata, be, we.
- Sub-module `riscv_mem_arb_prio`: combinational winner select plus the `starve_cnt` register.
- The FSM, payload latch, and timeout counter live in the top.

## Test plan
- Single fetch: `i_req`, addr 0x100; `mem_gnt` = 1 immediately; `mem_rvalid` in cycle 2 with 0xDEADBEEF → `i_gnt` in cycle 0, `mem_req` in cycle 1, `i_rvalid` in cycle 2 with `i_rdata` 0xDEADBEEF; `d_rvalid` stays 0.
- Contention: `i_req` and `d_req` high together, data store addr 0x200, be 4'b0011 → `d_gnt` only; `mem_we` = 1, `mem_be` = 4'b0011; fetch is granted in the cycle after `d_rvalid`.
- Starvation: `i_req` and `d_req` held high continuously with `STARVE_LIMIT` = 4 → grant order D, D, D, D, I, D, …; `starve_cnt` returns to 0 after I.
- Stall: `mem_gnt` held 0 for 5 cycles → `mem_req` and `mem_addr` stay constant for 6 cycles; no second gnt is issued.
- Reset mid-RESP, then `mem_rvalid` 1 cycle after reset → no `*_rvalid`; state IDLE; a new `d_req` is granted normally.
- Macro on, `TIMEOUT_CYCLES` = 8, no `mem_rvalid` → in cycle 8 of RESP: `mem_abort`, `d_rvalid`, `d_err` = 1, `d_rdata` = 0; next cycle IDLE.
